// File: rtl/flowled_sequencer_pkg.sv
// Shared encodings and default timing constants for the flow-LED sequencer.
package flowled_sequencer_pkg;

  localparam int unsigned T_STEP_DEF = 12_500_000;
  localparam int unsigned CNT_W_DEF  = 25;
  localparam int unsigned MODE_W     = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_SHL   = 2'd0,
    MODE_SHR   = 2'd1,
    MODE_PING  = 2'd2,
    MODE_BLINK = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/flowled_sequencer_if.sv
// Control/status bundle between a host and the flow-LED sequencer.
interface flowled_sequencer_if #(
  parameter int unsigned LED_NUM = 4
);
  logic               Start_Sig;
  logic               Stop_Sig;
  logic [1:0]         Mode_Sel;
  logic [1:0]         Speed_Sel;
  logic [LED_NUM-1:0] LED_Out;
  logic               Busy;
  logic               Step_Done;

  modport master (
    output Start_Sig, Stop_Sig, Mode_Sel, Speed_Sel,
    input  LED_Out, Busy, Step_Done
  );

  modport slave (
    input  Start_Sig, Stop_Sig, Mode_Sel, Speed_Sel,
    output LED_Out, Busy, Step_Done
  );
endinterface

// File: rtl/flowled_tick_gen.sv
// Prescale counter: wraps every len cycles while enabled; tick is a
// combinational strobe on the last count so the caller advances at that edge.
module flowled_tick_gen
  import flowled_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] len,
  output logic             tick
);
  logic [CNT_W-1:0] cnt;
  logic             at_end;

  assign at_end = (cnt == len - CNT_W'(1));
  assign tick   = enable && at_end;

  always_ff @(posedge CLK) begin
    if (!RSTn)       cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= at_end ? '0 : cnt + CNT_W'(1);
  end
endmodule

// File: rtl/flowled_sequencer.sv
// Running-light sequencer: IDLE/RUN control, latched mode/step length,
// and the LED pattern register advanced on each prescaler tick.
module flowled_sequencer
  import flowled_sequencer_pkg::*;
#(
  parameter int unsigned LED_NUM = 4,
  parameter int unsigned T_STEP  = T_STEP_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic         CLK,
  input  logic         RSTn,
  flowled_sequencer_if.slave bus
);
  localparam int unsigned POS_W = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(LED_NUM - 1);

  state_e             state, state_nxt;
  mode_e              mode_q, mode_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               dir_up_q, dir_up_d;
  logic [LED_NUM-1:0] led_q, led_d;
  logic               busy_q, busy_d;
  logic               step_done_q, step_done_d;
  logic               start_c, stop_c, tick;

  // Stop has priority over a simultaneous start.
  assign start_c = (state == ST_IDLE) && bus.Start_Sig && !bus.Stop_Sig;
  assign stop_c  = (state == ST_RUN) && bus.Stop_Sig;

  flowled_tick_gen #(.CNT_W(CNT_W)) u_tick (
    .CLK    (CLK),
    .RSTn   (RSTn),
    .clear  (start_c || stop_c),
    .enable (state == ST_RUN),
    .len    (len_q),
    .tick   (tick)
  );

  always_ff @(posedge CLK) begin
    if (!RSTn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start_c)     state_nxt = ST_RUN;
    else if (stop_c) state_nxt = ST_IDLE;
  end

  always_comb begin
    mode_d      = mode_q;
    len_d       = len_q;
    pos_d       = pos_q;
    dir_up_d    = dir_up_q;
    led_d       = led_q;
    busy_d      = busy_q;
    step_done_d = 1'b0;
    if (start_c) begin
      mode_d   = mode_e'(bus.Mode_Sel);
      len_d    = CNT_W'(T_STEP) >> bus.Speed_Sel;
      pos_d    = '0;
      dir_up_d = 1'b1;
      busy_d   = 1'b1;
      case (mode_e'(bus.Mode_Sel))
        MODE_SHR:   led_d = LED_NUM'(1) << (LED_NUM - 1);
        MODE_BLINK: led_d = '1;
        default:    led_d = LED_NUM'(1);
      endcase
    end else if (stop_c) begin
      led_d  = '0;
      busy_d = 1'b0;
    end else if ((state == ST_RUN) && tick) begin
      step_done_d = 1'b1;
      case (mode_q)
        MODE_SHL: led_d = {led_q[LED_NUM-2:0], led_q[LED_NUM-1]};
        MODE_SHR: led_d = {led_q[0], led_q[LED_NUM-1:1]};
        MODE_PING: begin
          // Flip direction on arriving at an end so end LEDs are not repeated.
          if (dir_up_q) begin
            pos_d = pos_q + POS_W'(1);
            if (pos_d == POS_LAST) dir_up_d = 1'b0;
          end else begin
            pos_d = pos_q - POS_W'(1);
            if (pos_d == '0) dir_up_d = 1'b1;
          end
          led_d = LED_NUM'(1) << pos_d;
        end
        default: led_d = ~led_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      mode_q      <= MODE_SHL;
      len_q       <= '0;
      pos_q       <= '0;
      dir_up_q    <= 1'b1;
      led_q       <= '0;
      busy_q      <= 1'b0;
      step_done_q <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      len_q       <= len_d;
      pos_q       <= pos_d;
      dir_up_q    <= dir_up_d;
      led_q       <= led_d;
      busy_q      <= busy_d;
      step_done_q <= step_done_d;
    end
  end

  assign bus.LED_Out   = led_q;
  assign bus.Busy      = busy_q;
  assign bus.Step_Done = step_done_q;
endmodule

// File: tb/tb_flowled_sequencer.sv
// Scoreboard bench for flowled_sequencer: directed plan scenarios then random traffic.
module tb_flowled_sequencer;
  localparam int N      = 4;
  localparam int TSTEP  = 8;

  typedef struct {
    logic [N-1:0] led;
    logic         busy;
    logic         sd;
    string        tag;
  } exp_t;

  logic clk;
  logic rstn;
  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t e_mon;

  // Reference model: elapsed cycles since start, step index = elapsed / len.
  bit m_run = 0;
  int m_mode = 0;
  int m_len = 1;
  int m_c = 0;

  flowled_sequencer_if #(.LED_NUM(N)) bus ();

  flowled_sequencer #(.LED_NUM(N), .T_STEP(TSTEP), .CNT_W(4)) dut (
    .CLK  (clk),
    .RSTn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N-1:0] pattern(input int mode, input int k);
    int p;
    int pos;
    case (mode)
      0: return N'(1 << (k % N));
      1: return N'(1 << (N - 1 - (k % N)));
      2: begin
        p   = k % (2 * N - 2);
        pos = (p < N) ? p : (2 * N - 2 - p);
        return N'(1 << pos);
      end
      default: return (k % 2 == 0) ? {N{1'b1}} : {N{1'b0}};
    endcase
  endfunction

  task automatic drive(input string tag, input logic r, input logic st, input logic sp,
                       input logic [1:0] m, input logic [1:0] s);
    exp_t e;
    @(negedge clk);
    rstn          = r;
    bus.Start_Sig = st;
    bus.Stop_Sig  = sp;
    bus.Mode_Sel  = m;
    bus.Speed_Sel = s;
    if (!r) begin
      m_run = 0;
    end else if (m_run) begin
      if (sp) m_run = 0;
      else    m_c++;
    end else if (st && !sp) begin
      m_run  = 1;
      m_mode = int'(m);
      m_len  = TSTEP >> s;
      m_c    = 0;
    end
    e.tag = tag;
    if (m_run) begin
      e.led  = pattern(m_mode, m_c / m_len);
      e.busy = 1'b1;
      e.sd   = (m_c > 0) && (m_c % m_len == 0);
    end else begin
      e.led  = '0;
      e.busy = 1'b0;
      e.sd   = 1'b0;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input string tag, input int n, input logic [1:0] m, input logic [1:0] s);
    for (int i = 0; i < n; i++) drive(tag, 1'b1, 1'b0, 1'b0, m, s);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      e_mon = exp_q.pop_front();
      checks++;
      if (bus.LED_Out !== e_mon.led || bus.Busy !== e_mon.busy || bus.Step_Done !== e_mon.sd) begin
        failures++;
        $display("FAIL %s t=%0t led=%b want %b busy=%b want %b step_done=%b want %b",
                 e_mon.tag, $time, bus.LED_Out, e_mon.led, bus.Busy, e_mon.busy,
                 bus.Step_Done, e_mon.sd);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn          = 1'b0;
    bus.Start_Sig = 1'b0;
    bus.Stop_Sig  = 1'b0;
    bus.Mode_Sel  = 2'd0;
    bus.Speed_Sel = 2'd0;

    // 1: reset, shift-left at len 8
    drive("reset", 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    drive("reset", 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
    drive("shl_start", 1'b1, 1'b1, 1'b0, 2'd0, 2'd0);
    idle("shl_run", 40, 2'd0, 2'd0);
    drive("shl_stop", 1'b1, 1'b0, 1'b1, 2'd0, 2'd0);
    idle("idle", 3, 2'd0, 2'd0);

    // 2: ping-pong at len 4
    drive("ping_start", 1'b1, 1'b1, 1'b0, 2'd2, 2'd1);
    idle("ping_run", 40, 2'd2, 2'd1);
    drive("ping_stop", 1'b1, 1'b0, 1'b1, 2'd2, 2'd1);

    // 3: blink at len 1, then stop
    drive("blink_start", 1'b1, 1'b1, 1'b0, 2'd3, 2'd3);
    idle("blink_run", 9, 2'd3, 2'd3);
    drive("blink_stop", 1'b1, 1'b0, 1'b1, 2'd3, 2'd3);
    idle("blink_after", 2, 2'd3, 2'd3);

    // 4: start+stop in idle; start during run at counter 5
    drive("ss_idle", 1'b1, 1'b1, 1'b1, 2'd0, 2'd0);
    idle("ss_idle_after", 3, 2'd0, 2'd0);
    drive("stop_in_idle", 1'b1, 1'b0, 1'b1, 2'd0, 2'd0);
    drive("rs_start", 1'b1, 1'b1, 1'b0, 2'd0, 2'd0);
    idle("rs_run", 5, 2'd0, 2'd0);
    drive("restart_ign", 1'b1, 1'b1, 1'b0, 2'd0, 2'd0);
    idle("rs_run2", 12, 2'd0, 2'd0);
    drive("rs_stop", 1'b1, 1'b0, 1'b1, 2'd0, 2'd0);

    // 5: mode/speed changes during run are ignored, next start picks them up
    drive("chg_start", 1'b1, 1'b1, 1'b0, 2'd0, 2'd0);
    idle("chg_run", 20, 2'd1, 2'd2);
    drive("chg_stop", 1'b1, 1'b0, 1'b1, 2'd1, 2'd2);
    drive("shr_start", 1'b1, 1'b1, 1'b0, 2'd1, 2'd2);
    idle("shr_run", 10, 2'd1, 2'd2);

    // 6: reset pulse mid-run
    drive("rst_mid", 1'b0, 1'b0, 1'b0, 2'd1, 2'd2);
    idle("rst_idle", 5, 2'd1, 2'd2);
    drive("post_rst_start", 1'b1, 1'b1, 1'b0, 2'd1, 2'd0);
    idle("post_rst_run", 10, 2'd1, 2'd0);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      drive("random",
            ($urandom_range(99) != 0),
            ($urandom_range(7) == 0),
            ($urandom_range(29) == 0),
            2'($urandom_range(3)),
            2'($urandom_range(3)));
    end
    idle("drain", 2, 2'd0, 2'd0);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
